// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: opcodes, instruction field bounds,
// fetch FSM states and the legal-opcode helper used when ILLEGAL_OPCODE_TRAP_EN is set.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI     = 8'h00;
    localparam logic [7:0] OP_MOV       = 8'h01;
    localparam logic [7:0] OP_ADD       = 8'h02;
    localparam logic [7:0] OP_SUB       = 8'h03;
    localparam logic [7:0] OP_AND       = 8'h04;
    localparam logic [7:0] OP_OR        = 8'h05;
    localparam logic [7:0] OP_J         = 8'h06;
    localparam logic [7:0] OP_BEQ       = 8'h07;
    localparam logic [7:0] OP_MAX_LEGAL = OP_BEQ;

    localparam int unsigned OPCODE_MSB    = 31;
    localparam int unsigned OPCODE_LSB    = 24;
    localparam int unsigned RD_OFFSET_MSB = 23;
    localparam int unsigned RD_OFFSET_LSB = 16;
    localparam int unsigned RT_MSB        = 15;
    localparam int unsigned RT_LSB        = 8;
    localparam int unsigned RS_IMM_MSB    = 7;
    localparam int unsigned RS_IMM_LSB    = 0;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_illegal_opcode(input logic [7:0] op);
        return op > OP_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential PC+4, or PC+4 plus a sign-extended word offset
// when a jump or a taken branch is signalled. Purely combinational.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [7:0]          offset,
    input  logic                jump,
    input  logic                branch,
    input  logic                zero,
    output logic                taken,
    output logic [PC_WIDTH-1:0] next_pc
);

    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] target_pc;

    // Offset counts words; wrap-around past either end of the address space is silent.
    assign offset_ext = {{(PC_WIDTH-8){offset[7]}}, offset};
    assign seq_pc     = pc + PC_WIDTH'(INSTR_BYTES);
    assign target_pc  = seq_pc + (offset_ext << 2);

    assign taken   = jump | (branch & zero);
    assign next_pc = taken ? target_pc : seq_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Non-pipelined fetch unit: IDLE -> FETCH -> ISSUE loop with a registered IR.
// Define ILLEGAL_OPCODE_TRAP_EN to halt on opcodes above OP_MAX_LEGAL and expose HALTED.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET_N,
    output logic                IMEM_READ,
    output logic [PC_WIDTH-1:0] IMEM_ADDRESS,
    input  logic [31:0]         IMEM_READDATA,
    input  logic                IMEM_BUSYWAIT,
    input  logic                STALL,
    input  logic                JUMP,
    input  logic                BRANCH,
    input  logic                ZERO,
    output logic [PC_WIDTH-1:0] PC,
    output logic [7:0]          OPCODE,
    output logic [7:0]          RD_OFFSET,
    output logic [7:0]          RT,
    output logic [7:0]          RS_IMM,
    output logic                INSTR_VALID
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    output logic                HALTED
`endif
);

    fetch_state_e        state;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         ir_q;
    logic                imem_read_q;
    logic                instr_valid_q;
    logic [PC_WIDTH-1:0] next_pc;
    logic                taken;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_calc (
        .pc      (pc_q),
        .offset  (ir_q[RD_OFFSET_MSB:RD_OFFSET_LSB]),
        .jump    (JUMP),
        .branch  (BRANCH),
        .zero    (ZERO),
        .taken   (taken),
        .next_pc (next_pc)
    );

`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic halted_q;
    logic ir_illegal;

    assign ir_illegal = is_illegal_opcode(ir_q[OPCODE_MSB:OPCODE_LSB]);
    assign HALTED     = halted_q;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ST_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= 32'h0;
            imem_read_q   <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state       <= ST_FETCH;
                    imem_read_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        ir_q        <= IMEM_READDATA;
                        imem_read_q <= 1'b0;
                        state       <= ST_ISSUE;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                        // An illegal word never shows as valid, even for its single cycle in ISSUE.
                        instr_valid_q <= !is_illegal_opcode(IMEM_READDATA[OPCODE_MSB:OPCODE_LSB]);
`else
                        instr_valid_q <= 1'b1;
`endif
                    end
                end
                ST_ISSUE: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    if (ir_illegal) begin
                        state         <= ST_HALT;
                        halted_q      <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end else
`endif
                    if (!STALL) begin
                        pc_q          <= next_pc;
                        state         <= ST_FETCH;
                        imem_read_q   <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Held until reset; PC stays at the faulting address.
                end
                default: begin
                    state         <= ST_IDLE;
                    imem_read_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_READ    = imem_read_q;
    assign IMEM_ADDRESS = pc_q;
    assign PC           = pc_q;
    assign INSTR_VALID  = instr_valid_q;
    assign OPCODE       = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign RD_OFFSET    = ir_q[RD_OFFSET_MSB:RD_OFFSET_LSB];
    assign RT           = ir_q[RT_MSB:RT_LSB];
    assign RS_IMM       = ir_q[RS_IMM_MSB:RS_IMM_LSB];

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Produces the instruction stream that the opcode decoder consumes.
- Owns the PC and fetches 32-bit instruction words from instruction memory over a READ/BUSYWAIT handshake.
- Latches each word into an instruction register, splits it into OPCODE and operand fields, and presents it for one issue cycle.
- Takes JUMP/BRANCH back from the decoder and ZERO from the ALU to compute the next PC.

Parameters:
- PC_WIDTH, 32, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- IMEM_READ  output  1  fetch request.
- IMEM_ADDRESS  output  PC_WIDTH  byte address of word being fetched (= PC).
- IMEM_READDATA  input  32  instruction word.
- IMEM_BUSYWAIT  input  1  memory not ready.
- STALL  input  1  downstream hold (data-memory busy); freezes issue.
- JUMP  input  1  from decoder, valid during issue cycle.
- BRANCH  input  1  from decoder, valid during issue cycle.
- ZERO  input  1  ALU zero flag, valid during issue cycle.
- PC  output  PC_WIDTH  address of instruction currently held in IR.
- OPCODE  output  8  IR[31:24].
- RD_OFFSET  output  8  IR[23:16]; destination register, or signed word offset for jump/beq.
- RT  output  8  IR[15:8].
- RS_IMM  output  8  IR[7:0].
- INSTR_VALID  output  1  IR holds an instruction being issued this cycle.
- HALTED  output  1  unit stopped (trap); present only with ILLEGAL_OPCODE_TRAP_EN.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE, PC=RESET_PC, IR=32'h0.
  - IMEM_READ=0, INSTR_VALID=0, HALTED=0.
  - Reset asserted in any state, including mid-fetch, aborts immediately; the in-flight memory response is ignored.
- States: IDLE, FETCH, ISSUE, HALT.
  - IDLE: first rising edge with RESET_N=1 goes to FETCH.
  - FETCH: IMEM_READ=1, IMEM_ADDRESS=PC held stable.
    - On the edge where IMEM_BUSYWAIT=0, IR <= IMEM_READDATA and state goes to ISSUE.
    - Otherwise remain in FETCH.
    - Minimum fetch latency is 1 cycle (zero-wait memory).
  - ISSUE: INSTR_VALID=1; IMEM_READ=0; fields drive from IR.
    - STALL=1: remain in ISSUE; PC and IR unchanged; INSTR_VALID stays 1.
    - STALL=0: on the edge, PC <= next_pc and state goes to FETCH.
  - HALT: described under Optional Feature.
- next_pc:
  - taken = JUMP | (BRANCH & ZERO).
  - taken=1: PC + 4 + (sign_extend(RD_OFFSET) << 2).
  - taken=0: PC + 4.
  - All arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
  - A backward offset past 0 wraps.
- JUMP, BRANCH and ZERO are sampled only at the ISSUE→FETCH edge and ignored in other states.
- BRANCH=1 with ZERO=0 is a fall-through.
- JUMP and BRANCH both 1 is treated as taken.
- Throughput: one instruction per (fetch latency + 1 + stall) cycles; no prefetch, no overlap.
- IMEM_BUSYWAIT outside FETCH is ignored.

Optional Feature:
- Macro ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - On entering ISSUE with IR[31:24] > 8'h07, INSTR_VALID=0 and the next edge goes to HALT.
  - HALT is held until reset: HALTED=1, IMEM_READ=0, INSTR_VALID=0, PC frozen at the faulting address.
  - STALL is ignored for an illegal instruction.
- Not defined:
  - The HALTED port is absent.
  - Undefined opcodes issue normally; the decoder leaves write-enable low, so they act as NOPs with PC+4 advance.

Decomposition:
- Package cpu_pkg:
  - Opcode localparams OP_LOADI..OP_BEQ (8'h00–8'h07) and OP_MAX_LEGAL=8'h07.
  - Field bit-range constants.
  - Fetch state enum.
  - INSTR_BYTES=4.
- One natural sub-module, pc_next_calc: combinational PC+4 plus sign-extended shifted offset and taken select. It is reused later by pipelined fetch.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0105 at address 0:
  - IMEM_READ=1 with IMEM_ADDRESS=0 the cycle after IDLE.
  - Next cycle INSTR_VALID=1, OPCODE=00, RD_OFFSET=00, RT=01, RS_IMM=05.
  - Following fetch at address 4.
- BUSYWAIT held high 3 cycles at address 8:
  - IMEM_ADDRESS stays 8 and IR is unchanged throughout.
  - IR loads on the first cycle with BUSYWAIT=0.
  - INSTR_VALID is asserted exactly once.
- Jump at PC=0x10 with RD_OFFSET=8'hFE: next fetch address 0x0C. With RD_OFFSET=8'h03: next fetch address 0x20.
- beq at PC=0x20 with offset 2:
  - ZERO=1: next fetch address 0x2C.
  - ZERO=0: next fetch address 0x24.
- STALL high 4 cycles during ISSUE:
  - INSTR_VALID stays 1 and PC is unchanged.
  - Fetch resumes at PC+4 one cycle after STALL falls.
- Illegal opcode and reset:
  - With ILLEGAL_OPCODE_TRAP_EN, opcode 8'h09 at PC=0x30 gives HALTED=1, PC=0x30, and no further IMEM_READ.
  - RESET_N pulsed low mid-FETCH returns PC=RESET_PC and drops IMEM_READ within the same cycle.
